// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - pixel types, framebuffer addressing and sink FSM states
package pixel_pkg;

  localparam int COLOR_W   = 8;
  localparam int DEPTH_W   = 16;
  localparam int COORD_W   = 10;
  localparam int FB_ADDR_W = 19;

  typedef logic [COLOR_W-1:0]   color_t;
  typedef logic [DEPTH_W-1:0]   depth_t;
  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  localparam depth_t DEPTH_FAR = '1;

  typedef struct packed {
    color_t red;
    color_t green;
    color_t blue;
    depth_t depth;
  } pixel_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    pixel_t pixel;
  } pixel_info_t;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_TEST, S_DROP, S_CLEAR} sink_state_t;

  // Linear framebuffer address, evaluated at the 19-bit address width.
  function automatic fb_addr_t fb_index(input coord_t x, input coord_t y, input int width);
    return fb_addr_t'(y) * fb_addr_t'(width) + fb_addr_t'(x);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, search starts one past the last grant
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= IW'(N - 1);
    end else if (advance && grant_valid) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/pixel_sink.sv
// rtl/pixel_sink.sv - rasterizer pixel sink: arbitrate, depth-test, commit, frame clear
module pixel_sink
  import pixel_pkg::*;
#(
  parameter int N_PORTS   = 4,
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480
) (
  input  logic                        clock,
  input  logic                        reset,
  input  pixel_info_t [N_PORTS-1:0]   data_out,
  input  logic [N_PORTS-1:0]          data_write,
  output logic [N_PORTS-1:0]          output_written,
  input  logic                        clear_start,
  input  pixel_t                      clear_color,
  output logic                        clear_busy,
  output fb_addr_t                    fb_addr,
  output logic                        fb_rd_en,
  input  pixel_t                      fb_rd_data,
  output logic                        fb_we,
  output pixel_t                      fb_wr_data
);
  localparam int       IW       = $clog2(N_PORTS);
  localparam fb_addr_t CLR_LAST = fb_addr_t'(FB_WIDTH * FB_HEIGHT - 1);

  sink_state_t        state, state_n;
  logic [N_PORTS-1:0] armed, pending, grant;
  logic [IW-1:0]      grant_idx, cur_port;
  logic               grant_valid, advance, take_clear, clear_req, in_range;
  pixel_info_t        sel;
  pixel_t             cur_pix, clr_pix;
  fb_addr_t           pix_addr, clr_addr;
  logic               unused_bits;

  assign unused_bits = ^{clear_color.depth, fb_rd_data.red, fb_rd_data.green, fb_rd_data.blue};

  // A port re-arms only after it drops data_write, so a held request is not served twice.
  assign pending = data_write & armed;

  rr_arbiter #(.N(N_PORTS)) u_arb (
    .clock       (clock),
    .reset       (reset),
    .req         (pending),
    .advance     (advance),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign sel      = data_out[grant_idx];
  assign in_range = (int'(sel.x) < FB_WIDTH) && (int'(sel.y) < FB_HEIGHT);

  always_comb begin
    state_n    = state;
    advance    = 1'b0;
    take_clear = 1'b0;
    case (state)
      S_IDLE: begin
        if (clear_start || clear_req) begin
          take_clear = 1'b1;
          state_n    = S_CLEAR;
        end else if (grant_valid) begin
          advance = 1'b1;
          state_n = in_range ? S_READ : S_DROP;
        end
      end
      S_READ:         state_n = S_TEST;
      S_TEST, S_DROP: state_n = S_IDLE;
      S_CLEAR:        if (clr_addr == CLR_LAST) state_n = S_IDLE;
      default:        state_n = S_IDLE;
    endcase
  end

  always_comb begin
    fb_rd_en   = (state == S_READ);
    clear_busy = (state == S_CLEAR);
    fb_we      = 1'b0;
    fb_addr    = '0;
    fb_wr_data = cur_pix;
    case (state)
      S_READ: fb_addr = pix_addr;
      S_TEST: begin
        fb_addr = pix_addr;
        fb_we   = cur_pix.depth < fb_rd_data.depth;
      end
      S_CLEAR: begin
        fb_addr    = clr_addr;
        fb_we      = 1'b1;
        fb_wr_data = clr_pix;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      output_written <= '1;
      armed          <= '1;
      clear_req      <= 1'b0;
      clr_addr       <= '0;
      clr_pix        <= '0;
      pix_addr       <= '0;
      cur_pix        <= '0;
      cur_port       <= '0;
    end else begin
      state <= state_n;
      armed <= (armed & ~(grant & {N_PORTS{advance}})) | ~data_write;

      // A clear requested mid-transaction waits here until the FSM is idle.
      if (take_clear)
        clear_req <= 1'b0;
      else if (clear_start && state != S_CLEAR)
        clear_req <= 1'b1;

      if (take_clear) begin
        clr_addr <= '0;
        clr_pix  <= '{red: clear_color.red, green: clear_color.green,
                      blue: clear_color.blue, depth: DEPTH_FAR};
      end else if (state == S_CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
      end

      if (advance) begin
        cur_port                  <= grant_idx;
        cur_pix                   <= sel.pixel;
        pix_addr                  <= fb_index(sel.x, sel.y, FB_WIDTH);
        output_written[grant_idx] <= 1'b0;
      end
      if (state == S_TEST || state == S_DROP)
        output_written[cur_port] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_sink.sv
// tb/tb_pixel_sink.sv - self-checking bench for pixel_sink
module tb_pixel_sink;
  import pixel_pkg::*;

  localparam int N = 4;
  localparam pixel_t BLANK   = '{red: 8'h00, green: 8'h00, blue: 8'h00, depth: 16'hFFFF};
  localparam pixel_t CLR_EXP = '{red: 8'hA1, green: 8'hB2, blue: 8'hC3, depth: 16'hFFFF};

  logic clock = 1'b0;
  logic reset;

  pixel_info_t [N-1:0] data_out, s_data_out;
  logic [N-1:0] data_write, output_written, s_data_write, s_output_written;
  logic clear_start, clear_busy, fb_rd_en, fb_we;
  logic s_clear_start, s_clear_busy, s_fb_rd_en, s_fb_we;
  pixel_t clear_color, fb_rd_data, fb_wr_data, s_clear_color, s_fb_rd_data, s_fb_wr_data;
  fb_addr_t fb_addr, s_fb_addr;

  pixel_sink #(.N_PORTS(N), .FB_WIDTH(640), .FB_HEIGHT(480)) dut (
    .clock(clock), .reset(reset), .data_out(data_out), .data_write(data_write),
    .output_written(output_written), .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_rd_data(fb_rd_data),
    .fb_we(fb_we), .fb_wr_data(fb_wr_data)
  );

  pixel_sink #(.N_PORTS(N), .FB_WIDTH(4), .FB_HEIGHT(2)) dut_s (
    .clock(clock), .reset(reset), .data_out(s_data_out), .data_write(s_data_write),
    .output_written(s_output_written), .clear_start(s_clear_start), .clear_color(s_clear_color),
    .clear_busy(s_clear_busy), .fb_addr(s_fb_addr), .fb_rd_en(s_fb_rd_en), .fb_rd_data(s_fb_rd_data),
    .fb_we(s_fb_we), .fb_wr_data(s_fb_wr_data)
  );

  always #5 clock = ~clock;

  // Framebuffer SRAM models: unwritten words read back as a cleared pixel.
  bit [39:0] mem [0:307199];
  bit        vld [0:307199];
  bit [39:0] s_mem [0:7];

  always @(posedge clock) begin
    if (fb_we) begin
      mem[fb_addr] <= fb_wr_data;
      vld[fb_addr] <= 1'b1;
    end
    if (fb_rd_en) fb_rd_data <= vld[fb_addr] ? pixel_t'(mem[fb_addr]) : BLANK;
    if (s_fb_we) s_mem[s_fb_addr[2:0]] <= s_fb_wr_data;
    if (s_fb_rd_en) s_fb_rd_data <= pixel_t'(s_mem[s_fb_addr[2:0]]);
  end

  typedef struct packed {
    fb_addr_t addr;
    pixel_t   data;
  } wr_t;

  typedef struct {
    int port;
    int x;
    int y;
    int depth;
    bit drop;
    bit we;
    int addr;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs [10];
  int   checks, failures, wcount;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clock);
      if (fb_we === 1'b1 && clear_busy === 1'b0) begin
        wcount++;
        check("sb_has_entry", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("wr_addr", fb_addr, e.addr);
          check("wr_data", fb_wr_data, e.data);
        end
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    pixel_t px;
    px = '{red: 8'(16 + idx), green: 8'h20, blue: 8'(48 + idx), depth: 16'(v.depth)};
    @(negedge clock);
    data_out[v.port]   = '{x: coord_t'(v.x), y: coord_t'(v.y), pixel: px};
    data_write[v.port] = 1'b1;
    if (v.we) sb.push_back('{addr: fb_addr_t'(v.addr), data: px});
    @(negedge clock);
    data_write[v.port] = 1'b0;
    check("ow_low_c1", output_written[v.port], 1'b0);
    check("rd_en_c1", fb_rd_en, !v.drop);
    if (!v.drop) check("rd_addr_c1", fb_addr, v.addr);
    @(negedge clock);
    check("ow_c2", output_written[v.port], v.drop);
    if (!v.drop) begin
      @(negedge clock);
      check("ow_c3", output_written[v.port], 1'b1);
    end
  endtask

  task automatic wait_grant(input int exp_port);
    int got = -1;
    for (int c = 0; c < 16 && got < 0; c++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++)
        if (output_written[i] == 1'b0) got = i;
    end
    check("grant_port", got, exp_port);
    for (int c = 0; c < 8 && output_written != 4'hF; c++) @(negedge clock);
    check("grant_ack", output_written, 4'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    pixel_t px;
    bit     seen;

    vecs[0] = '{port: 0, x: 5,   y: 7,   depth: 10,    drop: 0, we: 1, addr: 4485};
    vecs[1] = '{port: 2, x: 100, y: 200, depth: 20,    drop: 0, we: 1, addr: 128100};
    vecs[2] = '{port: 1, x: 100, y: 200, depth: 30,    drop: 0, we: 0, addr: 128100};
    vecs[3] = '{port: 3, x: 100, y: 200, depth: 20,    drop: 0, we: 0, addr: 128100};
    vecs[4] = '{port: 0, x: 100, y: 200, depth: 10,    drop: 0, we: 1, addr: 128100};
    vecs[5] = '{port: 1, x: 639, y: 479, depth: 0,     drop: 0, we: 1, addr: 307199};
    vecs[6] = '{port: 1, x: 0,   y: 480, depth: 5,     drop: 1, we: 0, addr: 0};
    vecs[7] = '{port: 2, x: 640, y: 0,   depth: 5,     drop: 1, we: 0, addr: 0};
    vecs[8] = '{port: 3, x: 0,   y: 0,   depth: 65534, drop: 0, we: 1, addr: 0};
    vecs[9] = '{port: 3, x: 1,   y: 0,   depth: 65535, drop: 0, we: 0, addr: 1};

    checks = 0; failures = 0; wcount = 0;
    reset = 1'b1;
    data_out = '0; data_write = '0; clear_start = 1'b0; clear_color = '0;
    s_data_out = '0; s_data_write = '0; s_clear_start = 1'b0;
    s_clear_color = '{red: 8'hA1, green: 8'hB2, blue: 8'hC3, depth: 16'h1234};
    fork
      monitor();
    join_none
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ow", output_written, 4'hF);
    check("rst_busy", clear_busy, 1'b0);
    check("rst_rd_en", fb_rd_en, 1'b0);
    check("rst_we", fb_we, 1'b0);
    check("rst_addr", fb_addr, 0);
    check("rst_s_ow", s_output_written, 4'hF);
    check("rst_s_we", s_fb_we, 1'b0);

    // Clear sweep on the 4x2 instance with a simultaneous pixel request on port 2.
    px = '{red: 8'h11, green: 8'h22, blue: 8'h33, depth: 16'd5};
    s_clear_start   = 1'b1;
    s_data_out[2]   = '{x: coord_t'(1), y: coord_t'(1), pixel: px};
    s_data_write[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("clr_busy", s_clear_busy, 1'b1);
      check("clr_we", s_fb_we, 1'b1);
      check("clr_addr", s_fb_addr, i);
      check("clr_data", s_fb_wr_data, CLR_EXP);
      check("clr_ow_hold", s_output_written, 4'hF);
      s_clear_start = (i == 3);
    end
    @(negedge clock);
    s_clear_start = 1'b0;
    check("clr_done_busy", s_clear_busy, 1'b0);
    check("clr_done_we", s_fb_we, 1'b0);
    @(negedge clock);
    s_data_write[2] = 1'b0;
    check("clr_px_rd", s_fb_rd_en, 1'b1);
    check("clr_px_addr", s_fb_addr, 5);
    check("clr_px_ow", s_output_written, 4'hB);
    @(negedge clock);
    check("clr_px_rdata", s_fb_rd_data, CLR_EXP);
    check("clr_px_we", s_fb_we, 1'b1);
    check("clr_px_wdata", s_fb_wr_data, px);
    @(negedge clock);
    check("clr_px_ack", s_output_written, 4'hF);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (s_clear_busy !== 1'b0 || s_fb_we !== 1'b0) seen = 1'b1;
    end
    check("clr_no_resweep", seen, 1'b0);

    // Table of single-pixel transactions on the 640x480 instance.
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
    @(negedge clock);
    check("tbl_sb_empty", sb.size(), 0);
    check("tbl_write_count", wcount, 5);

    // Fairness: all ports hold requests from a fresh pointer.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int p = 0; p < N; p++) begin
      px = '{red: 8'(p), green: 8'h55, blue: 8'h66, depth: 16'd100};
      data_out[p] = '{x: coord_t'(10 + p), y: coord_t'(3), pixel: px};
      sb.push_back('{addr: fb_addr_t'(1930 + p), data: px});
    end
    data_write = 4'hF;
    for (int p = 0; p < N; p++) wait_grant(p);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (output_written !== 4'hF || fb_rd_en !== 1'b0) seen = 1'b1;
    end
    check("no_regrant_held", seen, 1'b0);
    data_write[0] = 1'b0;
    @(negedge clock);
    px = '{red: 8'h77, green: 8'h55, blue: 8'h66, depth: 16'd100};
    data_out[0]   = '{x: coord_t'(20), y: coord_t'(3), pixel: px};
    data_write[0] = 1'b1;
    sb.push_back('{addr: fb_addr_t'(1940), data: px});
    wait_grant(0);
    data_write = '0;
    @(negedge clock);
    check("fair_sb_empty", sb.size(), 0);

    // Reset while a winning write is on the bus.
    px = '{red: 8'h99, green: 8'h88, blue: 8'h77, depth: 16'd7};
    data_out[2]   = '{x: coord_t'(50), y: coord_t'(50), pixel: px};
    data_write[2] = 1'b1;
    sb.push_back('{addr: fb_addr_t'(32050), data: px});
    @(negedge clock);
    data_write[2] = 1'b0;
    @(negedge clock);
    check("rstT_in_test", fb_we, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rstT_we", fb_we, 1'b0);
    check("rstT_ow", output_written, 4'hF);
    check("rstT_busy", clear_busy, 1'b0);

    // Reset in the middle of a clear sweep.
    clear_start = 1'b1;
    @(negedge clock);
    clear_start = 1'b0;
    check("rstC_busy_on", clear_busy, 1'b1);
    repeat (3) @(negedge clock);
    check("rstC_addr", fb_addr, 3);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rstC_we", fb_we, 1'b0);
    check("rstC_busy", clear_busy, 1'b0);
    check("rstC_ow", output_written, 4'hF);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (clear_busy !== 1'b0 || fb_we !== 1'b0) seen = 1'b1;
    end
    check("rstC_no_resume", seen, 1'b0);
    check("end_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
